// File: rtl/game_input_pkg.sv
// Shared definitions for the pushbutton input path feeding the game FSM,
// ship and munition blocks.
package game_input_pkg;

  localparam int BTN_A = 0;
  localparam int BTN_B = 1;
  localparam int BTN_C = 2;
  localparam int BTN_D = 3;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One pushbutton: two-flop synchroniser, stability debounce to an active-high
// level, press/release pulses and a press-plus-auto-repeat pulse train.
module button_channel
  import game_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic rpt_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  rpt_state_t    state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          press_q, release_q, rpt_q;
  logic          rise_s, fall_s, auto_s;

  // Synchroniser resets to the released (high) raw value.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: agreement clears the counter before any expiry is considered.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == ~level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = ~sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign rise_s = level_d & ~level_q;
  assign fall_s = ~level_d & level_q;

  // Repeat FSM: a release in the same cycle as an expiry suppresses the pulse.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    auto_s  = 1'b0;
    case (state_q)
      RPT_IDLE: begin
        if (rise_s) begin
          state_d = RPT_DELAY;
          rcnt_d  = '0;
        end else begin
          rcnt_d = '0;
        end
      end
      RPT_DELAY: begin
        if (fall_s || !level_q) begin
          state_d = RPT_IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == DELAY_LAST) begin
          auto_s  = 1'b1;
          state_d = RPT_REPEAT;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      RPT_REPEAT: begin
        if (fall_s || !level_q) begin
          state_d = RPT_IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == PERIOD_LAST) begin
          auto_s = 1'b1;
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RPT_IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  // State and registered outputs; reset overrides any coincident expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      level_q   <= 1'b0;
      state_q   <= RPT_IDLE;
      rcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      rpt_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      press_q   <= rise_s;
      release_q <= fall_s;
      rpt_q     <= rise_s | auto_s;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign rpt_o     = rpt_q;

endmodule

// File: rtl/input_conditioner.sv
// Conditions the raw active-low board pushbuttons into debounced levels,
// edge pulses and auto-repeat pulses, one independent channel per button.
module input_conditioner
  import game_input_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n_i,
  output logic [N_BTN-1:0] level_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic [N_BTN-1:0] rpt_o,
  output logic             any_press_o
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .btn_n_i  (btn_n_i[i]),
      .level_o  (level_o[i]),
      .press_o  (press_o[i]),
      .release_o(release_o[i]),
      .rpt_o    (rpt_o[i])
    );
  end

  assign any_press_o = |press_o;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with short debounce/repeat timings.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_n;
  logic [3:0] level, press, rel, rpt;
  logic       any_press;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  always #5 clk = ~clk;

  input_conditioner #(
    .N_BTN(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_n_i    (btn_n),
    .level_o    (level),
    .press_o    (press),
    .release_o  (rel),
    .rpt_o      (rpt),
    .any_press_o(any_press)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    btn_n = 4'hF;
    step(3);
    check("rst_level", level, 4'h0);
    check("rst_press", press, 4'h0);
    check("rst_release", rel, 4'h0);
    check("rst_rpt", rpt, 4'h0);
    check("rst_any", any_press, 1'b0);
    reset = 1'b0;
    step(8);
    check("idle_level", level, 4'h0);
    check("idle_press", press, 4'h0);

    // Clean press on A, then release.
    btn_n = 4'b1110;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      check("t1_pre_level", level, 4'h0);
      check("t1_pre_press", press, 4'h0);
    end
    step(1);
    check("t1_level", level, 4'b0001);
    check("t1_press", press, 4'b0001);
    check("t1_rpt", rpt, 4'b0001);
    check("t1_any", any_press, 1'b1);
    step(1);
    check("t1_press_end", press, 4'h0);
    check("t1_level_hold", level, 4'b0001);
    btn_n = 4'hF;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      check("t1_pre_release", rel, 4'h0);
      check("t1_no_rpt", rpt, 4'h0);
    end
    step(1);
    check("t1_release", rel, 4'b0001);
    check("t1_level_low", level, 4'h0);
    step(1);
    check("t1_release_end", rel, 4'h0);

    // Bounce on B: low 3, high 1, then low.
    btn_n = 4'b1101;
    step(3);
    btn_n = 4'hF;
    step(1);
    btn_n = 4'b1101;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      check("t2_pre_press", press, 4'h0);
      check("t2_pre_level", level, 4'h0);
    end
    step(1);
    check("t2_press", press, 4'b0010);
    check("t2_level", level, 4'b0010);
    step(1);
    check("t2_press_end", press, 4'h0);
    btn_n = 4'hF;
    step(6);
    check("t2_release", rel, 4'b0010);
    step(4);
    check("t2_level_low", level, 4'h0);

    // Auto-repeat on D, released so the fall meets a period expiry.
    btn_n = 4'b0111;
    step(6);
    for (int k = 0; k <= 40; k++) begin
      if (k != 0) step(1);
      check("t3_rpt", rpt,
            (k == 0 || (k >= 10 && (k - 10) % 3 == 0)) ? 4'b1000 : 4'b0000);
    end
    btn_n = 4'hF;
    for (int k = 41; k <= 50; k++) begin
      step(1);
      check("t3_rpt_tail", rpt, (k == 43) ? 4'b1000 : 4'b0000);
      check("t3_release", rel, (k == 46) ? 4'b1000 : 4'b0000);
    end
    check("t3_level_low", level, 4'h0);

    // All four buttons at once.
    btn_n = 4'b0000;
    step(5);
    check("t5_pre_press", press, 4'h0);
    step(1);
    check("t5_press", press, 4'hF);
    check("t5_any", any_press, 1'b1);
    check("t5_level", level, 4'hF);
    step(1);
    check("t5_press_end", press, 4'h0);
    check("t5_any_end", any_press, 1'b0);
    btn_n = 4'hF;
    step(6);
    check("t5_release", rel, 4'hF);
    check("t5_level_low", level, 4'h0);
    step(1);
    check("t5_release_end", rel, 4'h0);

    // Reset while C is held.
    btn_n = 4'b1011;
    step(6);
    check("t6_level", level, 4'b0100);
    step(2);
    reset = 1'b1;
    step(1);
    check("t6_rst_level", level, 4'h0);
    check("t6_rst_press", press, 4'h0);
    check("t6_rst_release", rel, 4'h0);
    check("t6_rst_rpt", rpt, 4'h0);
    check("t6_rst_any", any_press, 1'b0);
    step(1);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      check("t6_pre_press", press, 4'h0);
      check("t6_pre_level", level, 4'h0);
    end
    step(1);
    check("t6_press", press, 4'b0100);
    check("t6_level_again", level, 4'b0100);
    check("t6_rpt", rpt, 4'b0100);
    check("t6_any", any_press, 1'b1);
    btn_n = 4'hF;
    step(10);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
